// File: rtl/lsu_queue_pkg.sv
// Shared types and microop encodings for the load/store queue and its load-align helper.
package lsu_queue_pkg;

   localparam int LSU_DATA_WIDTH = 32;
   localparam int LSU_ADDR_BITS  = 32;
   localparam int LSU_R_WIDTH    = 6;
   localparam int LSU_MICROOP    = 5;
   localparam int LSU_ROB_TICKET = 3;

   localparam logic [LSU_MICROOP-1:0] LOAD_LB  = 5'b00001;
   localparam logic [LSU_MICROOP-1:0] LOAD_LH  = 5'b00010;
   localparam logic [LSU_MICROOP-1:0] LOAD_LW  = 5'b00011;
   localparam logic [LSU_MICROOP-1:0] LOAD_LBU = 5'b00100;
   localparam logic [LSU_MICROOP-1:0] LOAD_LHU = 5'b00101;
   localparam logic [LSU_MICROOP-1:0] STORE_SB = 5'b00110;
   localparam logic [LSU_MICROOP-1:0] STORE_SH = 5'b00111;
   localparam logic [LSU_MICROOP-1:0] STORE_SW = 5'b01000;

   localparam logic [3:0] CAUSE_LOAD_MISALIGNED = 4'd4;

   typedef struct packed {
      logic [LSU_DATA_WIDTH-1:0] data1;
      logic [LSU_DATA_WIDTH-1:0] data2;
      logic [LSU_DATA_WIDTH-1:0] immediate;
      logic [LSU_MICROOP-1:0]    microoperation;
      logic [LSU_ROB_TICKET-1:0] ticket;
      logic [LSU_R_WIDTH-1:0]    destination;
      logic                      valid;
   } to_execution;

   typedef struct packed {
      logic                      valid_entry;
      logic [LSU_R_WIDTH-1:0]    destination;
      logic [LSU_ROB_TICKET-1:0] ticket;
      logic [LSU_DATA_WIDTH-1:0] data;
      logic                      valid_exception;
      logic [3:0]                cause;
   } ex_update;

   typedef struct packed {
      logic                      is_store;
      logic [LSU_ADDR_BITS-1:0]  addr;
      logic [LSU_DATA_WIDTH-1:0] data;
      logic [LSU_MICROOP-1:0]    microop;
      logic [LSU_ROB_TICKET-1:0] ticket;
      logic [LSU_R_WIDTH-1:0]    dest;
   } lsq_entry_t;

   function automatic logic is_store_op(input logic [LSU_MICROOP-1:0] uop);
      return uop inside {STORE_SB, STORE_SH, STORE_SW};
   endfunction

endpackage

// File: rtl/lsu_queue_load_align.sv
// Byte/halfword/word select and extension of forwarded load data, with misalignment detection.
module lsu_load_align
   import lsu_queue_pkg::*;
(
   input  logic [LSU_MICROOP-1:0]    microop_i,
   input  logic [1:0]                addr_lo_i,
   input  logic [LSU_DATA_WIDTH-1:0] data_i,
   output logic [LSU_DATA_WIDTH-1:0] data_o,
   output logic                      exception_o,
   output logic [3:0]                cause_o
);

   logic [LSU_DATA_WIDTH-1:0] shifted;

   assign shifted = data_i >> {addr_lo_i, 3'b000};

   // NOTE: every output gets a default before the case so no path leaves a latch behind.
   always_comb begin
      data_o      = data_i;
      exception_o = 1'b0;
      case (microop_i)
         LOAD_LB:  data_o = {{(LSU_DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         LOAD_LBU: data_o = {{(LSU_DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         LOAD_LH: begin
            data_o      = {{(LSU_DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            exception_o = addr_lo_i[0];
         end
         LOAD_LHU: begin
            data_o      = {{(LSU_DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            exception_o = addr_lo_i[0];
         end
         LOAD_LW:  exception_o = |addr_lo_i;
         default:  data_o = data_i;
      endcase
      cause_o = exception_o ? CAUSE_LOAD_MISALIGNED : 4'd0;
   end

endmodule

// File: rtl/lsu_queue.sv
// In-order load/store issue queue: stores go to the ROB, loads forward or go to the cache.
// Optional perf counters are enabled by defining LSU_PERF_CNT_EN.
module lsu_queue
   import lsu_queue_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH,
   parameter int ADDR_BITS  = LSU_ADDR_BITS,
   parameter int R_WIDTH    = LSU_R_WIDTH,
   parameter int MICROOP    = LSU_MICROOP,
   parameter int ROB_TICKET = LSU_ROB_TICKET,
   parameter int LSQ_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid,
   input  logic [$bits(to_execution)-1:0] input_data,
   input  logic [$bits(ex_update)-1:0]  cache_fu_update,
   input  logic                         cache_blocked,
   input  logic                         flush,
   output logic [ADDR_BITS-1:0]         frw_address,
   output logic [MICROOP-1:0]           frw_microop,
   input  logic [DATA_WIDTH-1:0]        frw_data,
   input  logic                         frw_valid,
   input  logic                         frw_stall,
   input  logic                         cache_writeback_valid,
   output logic                         store_valid,
   output logic [ADDR_BITS-1:0]         store_address,
   output logic [DATA_WIDTH-1:0]        store_data,
   output logic [MICROOP-1:0]           store_microop,
   output logic [ROB_TICKET-1:0]        store_ticket,
   output logic                         cache_load_valid,
   output logic [ADDR_BITS-1:0]         cache_load_addr,
   output logic [R_WIDTH-1:0]           cache_load_dest,
   output logic [MICROOP-1:0]           cache_load_microop,
   output logic [ROB_TICKET-1:0]        cache_load_ticket,
   output logic                         output_used,
   output logic [$bits(ex_update)-1:0]  fu_update,
   output logic                         busy_fu,
   output logic [$clog2(LSQ_DEPTH):0]   lsq_count
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [127:0]                 perf_counters
`endif
);

   localparam int PTR_W = $clog2(LSQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LSQ_DEPTH);
   localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(LSQ_DEPTH - 1);

   to_execution op;
   lsq_entry_t  mem_q [LSQ_DEPTH];
   lsq_entry_t  head;
   lsq_entry_t  new_entry;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic enq, pop, head_valid, port_free;
   logic st_v, ld_v, fwd_v;
   logic [LSU_DATA_WIDTH-1:0] align_data;
   logic align_exc;
   logic [3:0] align_cause;
   ex_update fwd_update;

   assign op        = input_data;
   assign head      = mem_q[head_q];
   assign head_valid = (count_q != '0) && !flush;
   assign port_free = !cache_writeback_valid && !cache_blocked;
   assign enq       = valid && op.valid && (count_q != FULL_CNT) && !flush;

   assign new_entry.is_store = is_store_op(op.microoperation);
   assign new_entry.addr     = LSU_ADDR_BITS'(op.data1 + op.immediate);
   assign new_entry.data     = op.data2;
   assign new_entry.microop  = op.microoperation;
   assign new_entry.ticket   = op.ticket;
   assign new_entry.dest     = op.destination;

   // A stalled load keeps the head and re-probes forwarding every cycle.
   always_comb begin
      st_v  = 1'b0;
      ld_v  = 1'b0;
      fwd_v = 1'b0;
      pop   = 1'b0;
      if (head_valid) begin
         if (head.is_store) begin
            st_v = 1'b1;
            pop  = 1'b1;
         end else if (!frw_stall && port_free) begin
            fwd_v = frw_valid;
            ld_v  = !frw_valid;
            pop   = 1'b1;
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + PTR_W'(1);
         if (pop) head_d = head_q + PTR_W'(1);
         case ({enq, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         // NOTE: the payload is reset too; it is tiny and keeps frw_address defined after reset.
         for (int i = 0; i < LSQ_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (enq) mem_q[tail_q] <= new_entry;
      end
   end

   lsu_load_align u_align (
      .microop_i   (head.microop),
      .addr_lo_i   (head.addr[1:0]),
      .data_i      (frw_data),
      .data_o      (align_data),
      .exception_o (align_exc),
      .cause_o     (align_cause)
   );

   assign fwd_update.valid_entry     = 1'b1;
   assign fwd_update.destination     = head.dest;
   assign fwd_update.ticket          = head.ticket;
   assign fwd_update.data            = align_data;
   assign fwd_update.valid_exception = align_exc;
   assign fwd_update.cause           = align_cause;

   assign frw_address        = head.addr;
   assign frw_microop        = head.microop;
   assign store_valid        = st_v;
   assign store_address      = head.addr;
   assign store_data         = head.data;
   assign store_microop      = head.microop;
   assign store_ticket       = head.ticket;
   assign cache_load_valid   = ld_v;
   assign cache_load_addr    = head.addr;
   assign cache_load_dest    = head.dest;
   assign cache_load_microop = head.microop;
   assign cache_load_ticket  = head.ticket;
   assign output_used        = fwd_v;
   assign fu_update          = fwd_v ? fwd_update : cache_fu_update;
   assign busy_fu            = (count_q == FULL_CNT) || ((count_q == ALMOST_CNT) && enq && !pop);
   assign lsq_count          = count_q;

`ifdef LSU_PERF_CNT_EN
   logic [31:0] perf_q [4];
   logic [3:0]  perf_ev;

   assign perf_ev = {count_q == FULL_CNT, head_valid && !head.is_store && frw_stall, ld_v, fwd_v};

   // Counters saturate at all-ones and only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) perf_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (perf_ev[i] && (perf_q[i] != '1)) perf_q[i] <= perf_q[i] + 32'd1;
         end
      end
   end

   assign perf_counters = {perf_q[3], perf_q[2], perf_q[1], perf_q[0]};
`endif

endmodule

// File: tb/tb_lsu_queue.sv
// Directed bench for lsu_queue: scoreboard of expected head outputs plus per-step checks.
module tb_lsu_queue;
   import lsu_queue_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic valid;
   to_execution in_op;
   ex_update cache_upd;
   logic cache_blocked, flush, frw_valid, frw_stall, cache_writeback_valid;
   logic [31:0] frw_data;
   logic [31:0] frw_address, store_address, store_data, cache_load_addr;
   logic [4:0]  frw_microop, store_microop, cache_load_microop;
   logic [2:0]  store_ticket, cache_load_ticket;
   logic [5:0]  cache_load_dest;
   logic store_valid, cache_load_valid, output_used, busy_fu;
   logic [$bits(ex_update)-1:0] fu_update_raw;
   ex_update fu;
   logic [$clog2(DEPTH):0] lsq_count;
`ifdef LSU_PERF_CNT_EN
   logic [127:0] perf_counters;
`endif

   typedef struct {
      int          kind;   // 0 store, 1 cache load, 2 forwarded load
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  tkt;
      logic [5:0]  dst;
      logic        exc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   assign fu = fu_update_raw;

   always #5 clk = ~clk;

   lsu_queue #(.LSQ_DEPTH(DEPTH)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .valid                 (valid),
      .input_data            (in_op),
      .cache_fu_update       (cache_upd),
      .cache_blocked         (cache_blocked),
      .flush                 (flush),
      .frw_address           (frw_address),
      .frw_microop           (frw_microop),
      .frw_data              (frw_data),
      .frw_valid             (frw_valid),
      .frw_stall             (frw_stall),
      .cache_writeback_valid (cache_writeback_valid),
      .store_valid           (store_valid),
      .store_address         (store_address),
      .store_data            (store_data),
      .store_microop         (store_microop),
      .store_ticket          (store_ticket),
      .cache_load_valid      (cache_load_valid),
      .cache_load_addr       (cache_load_addr),
      .cache_load_dest       (cache_load_dest),
      .cache_load_microop    (cache_load_microop),
      .cache_load_ticket     (cache_load_ticket),
      .output_used           (output_used),
      .fu_update             (fu_update_raw),
      .busy_fu               (busy_fu),
      .lsq_count             (lsq_count)
`ifdef LSU_PERF_CNT_EN
      ,
      .perf_counters         (perf_counters)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [4:0] uop, input logic [31:0] base, input logic [31:0] imm,
                           input logic [31:0] d2, input logic [2:0] tkt, input logic [5:0] dst);
      in_op.data1          = base;
      in_op.immediate      = imm;
      in_op.data2          = d2;
      in_op.microoperation = uop;
      in_op.ticket         = tkt;
      in_op.destination    = dst;
      in_op.valid          = 1'b1;
      valid                = 1'b1;
   endtask

   task automatic push_exp(input int kind, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] tkt, input logic [5:0] dst, input logic exc);
      exp_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.tkt = tkt; e.dst = dst; e.exc = exc;
      sb.push_back(e);
   endtask

   // Output monitor: every head event must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (valid && in_op.valid) check("issue_into_full", lsq_count == DEPTH, 1'b0);
         if (store_valid || cache_load_valid || output_used) begin
            if (sb.size() == 0) begin
               check("unexpected_output", {store_valid, cache_load_valid, output_used}, 3'b000);
            end else begin
               e = sb.pop_front();
               check("event_kind", {store_valid, cache_load_valid, output_used},
                     (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001);
               if (e.kind == 0) begin
                  check("store_address", store_address, e.addr);
                  check("store_data", store_data, e.data);
                  check("store_ticket", store_ticket, e.tkt);
               end else if (e.kind == 1) begin
                  check("load_addr", cache_load_addr, e.addr);
                  check("load_ticket", cache_load_ticket, e.tkt);
                  check("load_dest", cache_load_dest, e.dst);
               end else begin
                  if (!e.exc) check("fwd_data", fu.data, e.data);
                  check("fwd_ticket", fu.ticket, e.tkt);
                  check("fwd_dest", fu.destination, e.dst);
                  check("fwd_exc", {fu.valid_entry, fu.valid_exception, fu.cause},
                        {1'b1, e.exc, e.exc ? 4'd4 : 4'd0});
               end
            end
         end
      end
   end

   initial begin
      int max_cnt;
      rst_n = 1'b0;
      valid = 1'b0;
      in_op = '0;
      cache_upd = '{valid_entry: 1'b1, destination: 6'd9, ticket: 3'd2, data: 32'h5A5A1234,
                    valid_exception: 1'b0, cause: 4'd0};
      cache_blocked = 1'b0; flush = 1'b0; frw_valid = 1'b0; frw_stall = 1'b0;
      cache_writeback_valid = 1'b0; frw_data = '0;

      // Reset state
      #12;
      check("rst_count", lsq_count, 0);
      check("rst_valids", {store_valid, cache_load_valid, output_used}, 3'b000);
      check("rst_busy", busy_fu, 1'b0);
      check("rst_fu_passthru", fu_update_raw, cache_upd);
      rst_n = 1'b1;
      tick();

      // Store burst: one store per cycle, queue never exceeds one entry
      max_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         drive_op(STORE_SW, 32'h100, 32'(4 * i), 32'(32'hA0 + i), 3'(i), 6'd0);
         push_exp(0, 32'(32'h100 + 4 * i), 32'(32'hA0 + i), 3'(i), 6'd0, 1'b0);
         tick();
         check("burst_store_valid", store_valid, 1'b1);
         if (int'(lsq_count) > max_cnt) max_cnt = int'(lsq_count);
      end
      valid = 1'b0;
      check("burst_peak_count", max_cnt, 1);
      tick();
      check("burst_drained", lsq_count, 0);
      check("burst_idle", store_valid, 1'b0);

      // Forward hit
      frw_valid = 1'b1;
      frw_data  = 32'hDEADBEEF;
      drive_op(LOAD_LW, 32'h1F0, 32'h10, 32'h0, 3'd5, 6'd7);
      push_exp(2, 32'h200, 32'hDEADBEEF, 3'd5, 6'd7, 1'b0);
      tick();
      valid = 1'b0;
      check("fwd_frw_address", frw_address, 32'h200);
      check("fwd_output_used", output_used, 1'b1);
      check("fwd_no_cache", cache_load_valid, 1'b0);
      tick();
      check("fwd_drained", lsq_count, 0);

      // Replay: stall wins over a hit for three cycles
      frw_stall = 1'b1;
      frw_data  = 32'h80112233;
      drive_op(LOAD_LBU, 32'h200, 32'h3, 32'h0, 3'd6, 6'd8);
      push_exp(2, 32'h203, 32'h00000080, 3'd6, 6'd8, 1'b0);
      tick();
      valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("replay_hold_outputs", {output_used, cache_load_valid}, 2'b00);
         check("replay_hold_count", lsq_count, 1);
         tick();
      end
      frw_stall = 1'b0;
      #1;
      check("replay_release", output_used, 1'b1);
      tick();
      check("replay_drained", lsq_count, 0);

      // Extraction: sign-extended byte/halfword and a misaligned word
      drive_op(LOAD_LB, 32'h203, 32'h0, 32'h0, 3'd1, 6'd2);
      push_exp(2, 32'h203, 32'hFFFFFF80, 3'd1, 6'd2, 1'b0);
      tick();
      drive_op(LOAD_LH, 32'h202, 32'h0, 32'h0, 3'd2, 6'd3);
      push_exp(2, 32'h202, 32'hFFFF8011, 3'd2, 6'd3, 1'b0);
      tick();
      drive_op(LOAD_LW, 32'h202, 32'h0, 32'h0, 3'd3, 6'd4);
      push_exp(2, 32'h202, 32'h0, 3'd3, 6'd4, 1'b1);
      tick();
      valid = 1'b0;
      tick();
      frw_valid = 1'b0;
      check("extract_drained", lsq_count, 0);

      // Full / backpressure
      cache_blocked = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_op(LOAD_LW, 32'h300, 32'(4 * i), 32'h0, 3'(i), 6'(10 + i));
         push_exp(1, 32'(32'h300 + 4 * i), 32'h0, 3'(i), 6'(10 + i), 1'b0);
         if (i == 3) begin
            #1;
            check("busy_on_last_fill", busy_fu, 1'b1);
         end
         tick();
         check("fill_count", lsq_count, i + 1);
      end
      valid = 1'b0;
      #1;
      check("full_busy", busy_fu, 1'b1);
      check("full_no_issue", cache_load_valid, 1'b0);
      cache_blocked = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_issue", cache_load_valid, 1'b1);
         check("drain_ticket_order", cache_load_ticket, 3'(i));
         tick();
      end
      check("drain_count", lsq_count, 0);
      check("drain_busy", busy_fu, 1'b0);

      // Cache port hazard
      cache_writeback_valid = 1'b1;
      drive_op(LOAD_LW, 32'h400, 32'h0, 32'h0, 3'd4, 6'd20);
      push_exp(1, 32'h400, 32'h0, 3'd4, 6'd20, 1'b0);
      tick();
      valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("hazard_hold", cache_load_valid, 1'b0);
         check("hazard_count", lsq_count, 1);
         tick();
      end
      cache_writeback_valid = 1'b0;
      #1;
      check("hazard_release", cache_load_valid, 1'b1);
      tick();
      check("hazard_drained", lsq_count, 0);

      // Flush with a concurrent issue
      cache_blocked = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_op(LOAD_LW, 32'h500, 32'(4 * i), 32'h0, 3'(i + 1), 6'd30);
         tick();
      end
      check("preflush_count", lsq_count, 3);
      flush = 1'b1;
      cache_blocked = 1'b0;
      drive_op(LOAD_LW, 32'h600, 32'h0, 32'h0, 3'd7, 6'd31);
      #1;
      check("flush_suppress", {store_valid, cache_load_valid, output_used}, 3'b000);
      tick();
      flush = 1'b0;
      valid = 1'b0;
      check("flush_count", lsq_count, 0);
      tick();
      check("flush_dropped_op", lsq_count, 0);
      check("flush_no_issue", cache_load_valid, 1'b0);

      // Asynchronous reset mid-operation
      cache_blocked = 1'b1;
      drive_op(LOAD_LW, 32'h700, 32'h0, 32'h0, 3'd1, 6'd1);
      tick();
      drive_op(LOAD_LW, 32'h704, 32'h0, 32'h0, 3'd2, 6'd2);
      tick();
      valid = 1'b0;
      check("prereset_count", lsq_count, 2);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_count", lsq_count, 0);
      check("midreset_busy", busy_fu, 1'b0);
      #2 rst_n = 1'b1;
      cache_blocked = 1'b0;
      tick();
      check("postreset_count", lsq_count, 0);
      check("postreset_no_issue", cache_load_valid, 1'b0);

      tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_queue.md
Name: lsu_queue

Overview:
- Parametrised successor to the 2-stage load/store functional unit.
- Replaces the single pipeline register with a LSQ_DEPTH-entry in-order issue queue.
- Computes effective address at enqueue and forwards stores to the ROB store interface.
- Loads probe ROB forwarding at the queue head, then either complete directly through an extraction helper or issue to the data cache. Forward-stalled loads replay in place; a flush port empties the queue on mispredict.

Parameters:
- DATA_WIDTH, 32, data/operand bits
- ADDR_BITS, 32, address bits
- R_WIDTH, 6, destination register bits
- MICROOP, 5, microoperation bits
- ROB_TICKET, 3, ROB ticket bits
- LSQ_DEPTH, 4, queue entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  issue strobe
- input_data  in  $bits(to_execution)  issued op (data1, data2, immediate, microoperation, ticket, destination, valid)
- cache_fu_update  in  $bits(ex_update)  cache writeback result
- cache_blocked  in  1  cache cannot accept load
- flush  in  1  discard all queued entries
- frw_address  out  ADDR_BITS  head-load address to ROB store search
- frw_microop  out  MICROOP  head-load microop
- frw_data  in  DATA_WIDTH  forwarded data
- frw_valid  in  1  forwarding hit
- frw_stall  in  1  partial overlap; the load must wait
- cache_writeback_valid  in  1  committed store occupying cache port
- store_valid  out  1  store to ROB
- store_address  out  ADDR_BITS  store address
- store_data  out  DATA_WIDTH  store data
- store_microop  out  MICROOP  store microop
- store_ticket  out  ROB_TICKET  store ticket
- cache_load_valid  out  1  load issue to cache
- cache_load_addr  out  ADDR_BITS  load address
- cache_load_dest  out  R_WIDTH  load destination
- cache_load_microop  out  MICROOP  load microop
- cache_load_ticket  out  ROB_TICKET  load ticket
- output_used  out  1  forwarded result owns fu_update
- fu_update  out  $bits(ex_update)  writeback result
- busy_fu  out  1  cannot accept next cycle
- lsq_count  out  $clog2(LSQ_DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0):
  - head, tail and count clear to 0; all entries invalid.
  - All valid outputs are 0; lsq_count is 0.
  - busy_fu is 0; fu_update equals cache_fu_update.
- Enqueue:
  - Occurs when valid & input_data.valid & count<LSQ_DEPTH.
  - Entry stores {is_store, addr = data1+immediate (mod 2^ADDR_BITS), data2, microop, ticket, destination}.
  - is_store = microop in {00110, 00111, 01000}.
  - An op issued into a full queue is a protocol violation; the bench asserts on it.
- busy_fu = (count==LSQ_DEPTH) | (count==LSQ_DEPTH-1 & enqueue & ~pop).
- Latency: an op enqueued in cycle N is at the head in cycle N+1 at the earliest; there is no same-cycle bypass.
- Head processing (combinational on head entry, one pop per cycle):
  - STORE: store_valid=1 and pop, unconditionally.
  - LOAD with frw_stall: hold the entry; no outputs; re-probe every cycle (replay).
  - LOAD with frw_valid:
    - If ~cache_writeback_valid & ~cache_blocked: output_used=1 and fu_update comes from the extraction result; pop.
    - Otherwise hold.
  - LOAD, no hit:
    - If ~cache_writeback_valid & ~cache_blocked: cache_load_valid=1; pop.
    - Otherwise hold.
- frw_address and frw_microop always reflect the head entry, even when no load is pending.
- fu_update mux: internal result when output_used, else cache_fu_update.
- Extraction for forwarded loads:
  - LB/LBU/LH/LHU/LW byte-select and sign/zero-extend by microop.
  - A misaligned halfword or word sets valid_exception with cause 4 (load address misaligned).
- Simultaneous enqueue+pop: count unchanged; when full, an enqueue is accepted on the same cycle as a pop only if busy_fu was 0 in the previous cycle.
- Pointers wrap modulo LSQ_DEPTH.
- Flush:
  - Next edge: count=0 and head=tail=0.
  - Same-cycle head outputs are suppressed (all valids 0).
  - An enqueue in the flush cycle is dropped.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Enabled:
  - Adds 32-bit saturating counters for forwarded loads, cache-issued loads, replay-stall cycles and full cycles.
  - Counters are exposed on output perf_counters[127:0] and cleared by reset and by nothing else.
- Disabled: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared structs package:
  - to_execution and ex_update types.
  - Store microop constants (STORE_SB/SH/SW).
  - Load microop constants.
  - lsq_entry_t typedef.
- Sub-module lsu_load_align: combinational data select/extend plus misalignment exception.

Test Plan:
- Store burst: 4 SW, addr=0x100+4i, data2=0xA0+i, no stalls → store_valid on 4 consecutive cycles starting cycle 1; lsq_count peaks at 1.
- Forward hit: LW addr 0x200, frw_valid=1, frw_data=0xDEADBEEF → output_used=1, fu_update.data=0xDEADBEEF, cache_load_valid=0.
- Replay: LBU 0x203, frw_stall high 3 cycles, then hit with frw_data=0x80112233 → no output for 3 cycles; then fu_update.data=0x00000080.
- Full/backpressure: cache_blocked=1, enqueue 4 LW → busy_fu=1 once count reaches 4; release → 4 cache_load_valid pulses in order of ticket 0..3.
- Port hazard: cache_writeback_valid=1 with a load at head → hold; the load issues the cycle cache_writeback_valid drops.
- Flush: 3 loads queued, flush with a concurrent valid issue → lsq_count=0 next cycle, no load issued, new op dropped.
